pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter WIDTH, default 32, data path width in bits (legal 1..128).
REQ-002 Parameter RESET_DATA, default 0, value loaded into data registers on reset (WIDTH bits).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port flush  input  1  synchronous discard of all held entries.
REQ-006 Port in_valid  input  1  upstream presents in_data.
REQ-007 Port in_data  input  WIDTH  upstream payload.
REQ-008 Port in_ready  output  1  block can accept; transfer when in_valid & in_ready at clk edge.
REQ-009 Port out_valid  output  1  out_data holds a valid entry.
REQ-010 Port out_data  output  WIDTH  head payload.
REQ-011 Port out_ready  input  1  downstream accepts; transfer when out_valid & out_ready at clk edge.
REQ-012 Port occ  output  2  number of held entries, 0..2.

Function
REQ-013 Block SHALL hold up to two entries: main register (drives out_data) and skid register.
REQ-014 State machine SHALL have states EMPTY (occ=0), ONE (occ=1), FULL (occ=2).
REQ-015 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, decoded only from state (no combinational path from out_ready).
REQ-016 out_valid SHALL be 1 in ONE and FULL, 0 in EMPTY; out_data SHALL equal main register.
REQ-017 Latency: data accepted at edge N SHALL appear on out_data with out_valid=1 after edge N when block was EMPTY.
REQ-018 EMPTY: accept -> ONE, main <= in_data; no accept -> stay EMPTY.
REQ-019 ONE: accept & pop -> ONE, main <= in_data; accept only -> FULL, skid <= in_data; pop only -> EMPTY; neither -> hold.
REQ-020 FULL: pop -> ONE, main <= skid; no pop -> hold; no accept possible.
REQ-021 Order SHALL be strictly FIFO; no entry duplicated or lost except by flush or reset.
REQ-022 While out_valid=1 and out_ready=0, out_data SHALL remain stable.
REQ-023 flush=1 SHALL force EMPTY at next edge, overriding any same-cycle accept or pop; the input offered that cycle is discarded even if in_ready=1.
REQ-024 Data registers SHALL NOT change on flush (only state changes); out_data content while EMPTY is don't-care for checks.
REQ-025 occ SHALL be a registered function of state: EMPTY=0, ONE=1, FULL=2; value 3 never produced.

Reset
REQ-026 rst=1 SHALL immediately (no clock) force EMPTY: out_valid=0, in_ready=1, occ=0, main and skid = RESET_DATA.
REQ-027 Reset mid-operation SHALL discard all held entries; first accept after release follows REQ-018.
REQ-028 Release of rst SHALL be synchronous to clk by the integrating level; no internal synchroniser.

Structure
REQ-029 Shared package pipe_pkg SHALL hold the state enumeration (EMPTY, ONE, FULL) and occupancy width constant OCC_W=2.
REQ-030 One sub-module pipe_dffe SHALL implement a WIDTH-parametrised enable register with async active-high reset to RESET_DATA, instantiated for main and skid.
REQ-031 Next-state and register-enable logic SHALL reside in pipe_skid_reg; no latches; single clock domain.

Verification
REQ-032 Reset: assert rst mid-cycle with occ=2 -> out_valid=0, in_ready=1, occ=0, out_data=RESET_DATA without clock edge.
REQ-033 Streaming: out_ready=1, in_valid=1 for 8 cycles with data 0x10..0x17 -> out_data 0x10..0x17 on consecutive cycles, 1-cycle latency, occ stays 1.
REQ-034 Backpressure: out_ready=0, offer 0xA1,0xA2,0xA3 -> 0xA1,0xA2 accepted, in_ready=0 after second, occ=2, out_data=0xA1 stable; then out_ready=1 -> 0xA1,0xA2 delivered, then 0xA3.
REQ-035 Simultaneous in ONE: main=0x55, in_data=0x66 accept & pop same edge -> out_data=0x66, occ=1.
REQ-036 Flush: occ=2 with flush=1 and in_valid=1 (0x77) -> next edge occ=0, out_valid=0, 0x77 never emerges.
REQ-037 Random valid/ready (10k cycles, WIDTH=8 and WIDTH=1) against scoreboard queue -> zero ordering or loss mismatches, occ never 3.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the two-entry skid register: state encoding and occupancy width.
// State encoding matches occupancy so occ is a direct decode of the state register.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [OCC_W-1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  function automatic logic [OCC_W-1:0] state_occ(input state_t s);
    logic [OCC_W-1:0] v;
    v = '0;
    case (s)
      EMPTY:   v = 2'd0;
      ONE:     v = 2'd1;
      FULL:    v = 2'd2;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/pipe_dffe.sv
// Enable register with asynchronous active-high reset to RESET_DATA.
// Latency 1 cycle when enabled; holds otherwise, no flow control of its own.
module pipe_dffe #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_DATA;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline register (main + skid): 1-cycle latency from accept to out_valid.
// in_ready decodes from state only, so upstream never sees a combinational path from out_ready.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occ
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_pop;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_sel_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign out_data  = w_main_q;
  assign occ       = state_occ(r_state);

  assign w_accept = in_valid & in_ready;
  assign w_pop    = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Flush only moves the state; the data registers keep their stale contents.
  always_comb begin
    w_state_nxt     = r_state;
    w_main_en       = 1'b0;
    w_skid_en       = 1'b0;
    w_main_sel_skid = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_main_en   = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_main_en = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = FULL;
            w_skid_en   = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          if (w_pop) begin
            w_state_nxt     = ONE;
            w_main_en       = 1'b1;
            w_main_sel_skid = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;

  pipe_dffe #(
    .WIDTH     (WIDTH),
    .RESET_DATA(RESET_DATA)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .i_en(w_main_en),
    .i_d (w_main_d),
    .o_q (w_main_q)
  );

  pipe_dffe #(
    .WIDTH     (WIDTH),
    .RESET_DATA(RESET_DATA)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .i_en(w_skid_en),
    .i_d (in_data),
    .o_q (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table, async reset corner, and a
// random valid/ready run on WIDTH=8 and WIDTH=1 instances against queue models.
module tb_pipe_skid_reg;

  logic       clk = 1'b0;
  logic       rst;
  logic       fl8, iv8, or8, ir8, ov8;
  logic [7:0] id8, od8;
  logic [1:0] occ8;
  logic       fl1, iv1, or1, ir1, ov1;
  logic [0:0] id1, od1;
  logic [1:0] occ1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_ir;
    logic [1:0] e_occ;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] q8[$];
  logic       q1[$];
  logic       a8, p8, a1, p1;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(8), .RESET_DATA(8'h5A)) dut8 (
    .clk(clk), .rst(rst), .flush(fl8), .in_valid(iv8), .in_data(id8),
    .in_ready(ir8), .out_valid(ov8), .out_data(od8), .out_ready(or8), .occ(occ8)
  );

  pipe_skid_reg #(.WIDTH(1), .RESET_DATA(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(fl1), .in_valid(iv1), .in_data(id1),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(or1), .occ(occ1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic iv, input logic [7:0] id, input logic ordy,
                     input logic e_ov, input logic [7:0] e_od, input logic e_ir,
                     input logic [1:0] e_occ);
    vec_t v;
    v.fl = fl; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ov = e_ov; v.e_od = e_od; v.e_ir = e_ir; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  initial begin
    // streaming: 1-cycle latency, occupancy stays at one
    for (int k = 0; k < 8; k++) add(0, 1, 8'h10 + 8'(k), 1, 1, 8'h10 + 8'(k), 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    // backpressure: third offer refused while full
    add(0, 1, 8'hA1, 0, 1, 8'hA1, 1, 1);
    add(0, 1, 8'hA2, 0, 1, 8'hA1, 0, 2);
    add(0, 1, 8'hA3, 0, 1, 8'hA1, 0, 2);
    add(0, 1, 8'hA3, 1, 1, 8'hA2, 1, 1);
    add(0, 1, 8'hA3, 1, 1, 8'hA3, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    // simultaneous accept and pop in ONE
    add(0, 1, 8'h55, 0, 1, 8'h55, 1, 1);
    add(0, 1, 8'h66, 1, 1, 8'h66, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    // flush from FULL with an offered input, then flush from ONE with accept+pop
    add(0, 1, 8'h81, 0, 1, 8'h81, 1, 1);
    add(0, 1, 8'h82, 0, 1, 8'h81, 0, 2);
    add(1, 1, 8'h77, 0, 0, 8'h00, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    add(0, 1, 8'h90, 0, 1, 8'h90, 1, 1);
    add(1, 1, 8'h93, 1, 0, 8'h00, 1, 0);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);
    add(0, 1, 8'h94, 1, 1, 8'h94, 1, 1);
    add(0, 0, 8'h00, 1, 0, 8'h00, 1, 0);

    rst = 1'b1;
    fl8 = 0; iv8 = 0; id8 = '0; or8 = 0;
    fl1 = 0; iv1 = 0; id1 = '0; or1 = 0;
    #1;
    check("rst0.ov8", ov8, 0);
    check("rst0.ir8", ir8, 1);
    check("rst0.occ8", occ8, 0);
    check("rst0.od8", od8, 8'h5A);
    check("rst0.od1", od1, 1);
    check("rst0.occ1", occ1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      fl8 = vecs[i].fl; iv8 = vecs[i].iv; id8 = vecs[i].id; or8 = vecs[i].ordy;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.ov", i), ov8, vecs[i].e_ov);
      check($sformatf("vec%0d.ir", i), ir8, vecs[i].e_ir);
      check($sformatf("vec%0d.occ", i), occ8, vecs[i].e_occ);
      if (vecs[i].e_ov) check($sformatf("vec%0d.od", i), od8, vecs[i].e_od);
    end

    // asynchronous reset while full, checked without a clock edge
    @(negedge clk);
    fl8 = 0; iv8 = 1; id8 = 8'hC1; or8 = 0;
    @(negedge clk);
    id8 = 8'hC2;
    @(negedge clk);
    iv8 = 0;
    #1 check("mid.occ_pre", occ8, 2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid.ov", ov8, 0);
    check("mid.ir", ir8, 1);
    check("mid.occ", occ8, 0);
    check("mid.od", od8, 8'h5A);
    @(negedge clk);
    rst = 1'b0; iv8 = 1; id8 = 8'hD1;
    @(posedge clk);
    #1;
    check("post.ov", ov8, 1);
    check("post.od", od8, 8'hD1);
    check("post.occ", occ8, 1);
    @(negedge clk);
    iv8 = 0; or8 = 1;
    @(posedge clk);
    #1 check("post.drain", occ8, 0);

    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      fl8 = ($urandom_range(63) == 0); iv8 = 1'($urandom_range(1));
      id8 = 8'($urandom);               or8 = 1'($urandom_range(1));
      fl1 = ($urandom_range(63) == 0); iv1 = 1'($urandom_range(1));
      id1 = 1'($urandom_range(1));      or1 = 1'($urandom_range(1));
      #1;
      check("rnd8.occ", occ8, q8.size());
      check("rnd8.ov", ov8, q8.size() != 0);
      check("rnd8.ir", ir8, q8.size() < 2);
      if (ov8 && q8.size() > 0) check("rnd8.od", od8, q8[0]);
      check("rnd1.occ", occ1, q1.size());
      check("rnd1.ov", ov1, q1.size() != 0);
      check("rnd1.ir", ir1, q1.size() < 2);
      if (ov1 && q1.size() > 0) check("rnd1.od", od1, q1[0]);
      a8 = iv8 & ir8 & ~fl8;
      p8 = ov8 & or8 & ~fl8;
      a1 = iv1 & ir1 & ~fl1;
      p1 = ov1 & or1 & ~fl1;
      if (fl8) q8.delete();
      else begin
        if (p8 && q8.size() > 0) void'(q8.pop_front());
        if (a8) q8.push_back(id8);
      end
      if (fl1) q1.delete();
      else begin
        if (p1 && q1.size() > 0) void'(q1.pop_front());
        if (a1) q1.push_back(id1[0]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
